can_rx_frame_ctrl: RTL and testbench

Receive-side frame sequencer for the CAN 2.0A path.
- Detects bus idle and start-of-frame (SOF) on the raw rx line.
- Drives the enable of the mid-bit sampler from SOF to the CRC delimiter.
- Consumes the sampler's bit/valid stream, removes stuff bits and walks the frame fields.
- Presents the decoded ID, RTR, DLC, data and CRC plus error pulses to downstream logic.

---
 rtl/can_pkg.sv | 34 +++
 rtl/can_crc15.sv | 28 ++
 rtl/can_rx_frame_ctrl.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_can_rx_frame_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// can_pkg: shared types and constants for the CAN 2.0A receive path.
//   state_t     - frame sequencer states
//   *_LEN       - field widths (identifier, DLC, CRC)
//   STUFF_LIMIT - equal-bit run length after which a stuff bit follows
//   crc15_step  - one serial step of the CAN CRC-15
package can_pkg;

   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      SOF,
      ARB,
      CTRL,
      DATA,
      CRC,
      CRC_DEL
   } state_t;

   localparam int unsigned ID_LEN      = 11;
   localparam int unsigned DLC_LEN     = 4;
   localparam int unsigned CRC_LEN     = 15;
   localparam int unsigned STUFF_LIMIT = 5;

   localparam logic [CRC_LEN-1:0] CRC15_POLY = 15'h4599;

   // Shift one bit into the CRC-15 register (MSB-first, feedback on msb xor bit).
   function automatic logic [CRC_LEN-1:0] crc15_step(input logic [CRC_LEN-1:0] crc,
                                                     input logic               b);
      logic fb;
      fb = b ^ crc[CRC_LEN-1];
      return {crc[CRC_LEN-2:0], 1'b0} ^ (fb ? CRC15_POLY : '0);
   endfunction

endpackage

// File: rtl/can_crc15.sv
// can_crc15: serial CRC-15 accumulator over destuffed frame bits.
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - synchronous return to the zero seed
//   bit_valid  - advance the register with bit_in
//   bit_in     - destuffed frame bit
//   crc        - running CRC value
module can_crc15
   import can_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               bit_valid,
   input  logic               bit_in,
   output logic [CRC_LEN-1:0] crc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc <= '0;
      end else if (clear) begin
         crc <= '0;
      end else if (bit_valid) begin
         crc <= crc15_step(crc, bit_in);
      end
   end

endmodule

// File: rtl/can_rx_frame_ctrl.sv
// can_rx_frame_ctrl: CAN 2.0A receive frame sequencer.
// Waits for bus idle, catches SOF on rx, enables the mid-bit sampler, destuffs
// the sampled stream and walks ARB/CTRL/DATA/CRC/CRC_DEL.
//   clk, rst_n          - clock, asynchronous active-low reset
//   rx                  - synchronised bus line (1 = recessive)
//   bit_in, bit_valid   - sampler output and its one-clk strobe
//   sample_en           - sampler enable, SOF through CRC delimiter
//   id, rtr, dlc, data  - decoded fields (data byte0 in [63:56])
//   crc_rx              - received CRC field
//   frame_valid, stuff_err, form_err - one-clk result pulses
//   busy                - high outside IDLE
// Optional: CAN_RX_CRC_CHECK_EN adds crc_err and a CRC-15 check at the delimiter.
module can_rx_frame_ctrl
   import can_pkg::*;
#(
   parameter int unsigned CLK_SPEED_MHZ      = 100,
   parameter int unsigned CAN_BIT_RATE_KBITS = 1000,
   parameter int unsigned IDLE_BITS          = 11
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rx,
   input  logic               bit_in,
   input  logic               bit_valid,
   output logic               sample_en,
   output logic [ID_LEN-1:0]  id,
   output logic               rtr,
   output logic [DLC_LEN-1:0] dlc,
   output logic [63:0]        data,
   output logic [CRC_LEN-1:0] crc_rx,
   output logic               frame_valid,
   output logic               stuff_err,
   output logic               form_err,
   output logic               busy
`ifdef CAN_RX_CRC_CHECK_EN
   ,
   output logic               crc_err
`endif
);

   localparam int unsigned CPB       = CLK_SPEED_MHZ * 1000 / CAN_BIT_RATE_KBITS;
   localparam int unsigned IDLE_CLKS = IDLE_BITS * CPB;
   localparam int unsigned IDLE_W    = $clog2(IDLE_CLKS + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CLKS - 1);

   state_t              state, state_d;
   logic [IDLE_W-1:0]   idle_cnt, idle_cnt_d;
   logic [6:0]          cnt, cnt_d;
   logic [6:0]          len, len_d;
   logic                run_val, run_val_d;
   logic [2:0]          run_cnt, run_cnt_d;
   logic [ID_LEN-1:0]   id_d;
   logic                rtr_d;
   logic [DLC_LEN-1:0]  dlc_d, dlc_n, dlc_cap;
   logic [63:0]         data_d;
   logic [CRC_LEN-1:0]  crc_rx_d;
   logic                sample_en_d, frame_valid_d, stuff_err_d, form_err_d, busy_d;
   logic                bit_take;
   logic                field_bit;

   // Sampler strobes are only meaningful while the sampler is enabled.
   assign bit_take = bit_valid & sample_en;

`ifdef CAN_RX_CRC_CHECK_EN
   logic               crc_err_d;
   logic               crc_feed;
   logic [CRC_LEN-1:0] crc_calc;

   // CRC covers destuffed bits from SOF through the last data bit.
   assign crc_feed = field_bit &
                     ((state == SOF) || (state == ARB) || (state == CTRL) || (state == DATA));

   can_crc15 u_crc15 (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (state == IDLE),
      .bit_valid (crc_feed),
      .bit_in    (bit_in),
      .crc       (crc_calc)
   );
`endif

   // Next-state and next-output logic.
   always_comb begin
      state_d       = state;
      idle_cnt_d    = '0;
      cnt_d         = cnt;
      len_d         = len;
      run_val_d     = run_val;
      run_cnt_d     = run_cnt;
      id_d          = id;
      rtr_d         = rtr;
      dlc_d         = dlc;
      dlc_n         = dlc;
      dlc_cap       = dlc;
      data_d        = data;
      crc_rx_d      = crc_rx;
      sample_en_d   = sample_en;
      frame_valid_d = 1'b0;
      stuff_err_d   = 1'b0;
      form_err_d    = 1'b0;
      field_bit     = 1'b0;
`ifdef CAN_RX_CRC_CHECK_EN
      crc_err_d     = 1'b0;
`endif

      case (state)
         WAIT_IDLE: begin
            sample_en_d = 1'b0;
            if (rx) begin
               if (idle_cnt == IDLE_LAST) begin
                  state_d = IDLE;
               end else begin
                  idle_cnt_d = idle_cnt + IDLE_W'(1);
               end
            end
         end
         IDLE: begin
            id_d     = '0;
            rtr_d    = 1'b0;
            dlc_d    = '0;
            data_d   = '0;
            crc_rx_d = '0;
            cnt_d    = '0;
            len_d    = '0;
            if (!rx) begin
               sample_en_d = 1'b1;
               state_d     = SOF;
            end
         end
         SOF: begin
            if (bit_take) begin
               if (bit_in) begin
                  // Recessive at the sample point: the falling edge was a glitch.
                  sample_en_d = 1'b0;
                  state_d     = WAIT_IDLE;
               end else begin
                  run_val_d = 1'b0;
                  run_cnt_d = 3'd1;
                  cnt_d     = '0;
                  field_bit = 1'b1;
                  state_d   = ARB;
               end
            end
         end
         ARB, CTRL, DATA, CRC: begin
            if (bit_take) begin
               if (run_cnt == 3'(STUFF_LIMIT)) begin
                  if (bit_in == run_val) begin
                     stuff_err_d = 1'b1;
                     sample_en_d = 1'b0;
                     state_d     = WAIT_IDLE;
                  end else begin
                     run_val_d = bit_in;
                     run_cnt_d = 3'd1;
                  end
               end else begin
                  if (bit_in == run_val) begin
                     run_cnt_d = run_cnt + 3'd1;
                  end else begin
                     run_val_d = bit_in;
                     run_cnt_d = 3'd1;
                  end
                  field_bit = 1'b1;
               end
            end
         end
         CRC_DEL: begin
            if (bit_take) begin
               sample_en_d = 1'b0;
               state_d     = WAIT_IDLE;
               if (!bit_in) begin
                  form_err_d = 1'b1;
               end else begin
`ifdef CAN_RX_CRC_CHECK_EN
                  if (crc_calc != crc_rx) begin
                     crc_err_d = 1'b1;
                  end else begin
                     frame_valid_d = 1'b1;
                  end
`else
                  frame_valid_d = 1'b1;
`endif
               end
            end
         end
         default: begin
            state_d = WAIT_IDLE;
         end
      endcase

      // Field walk on destuffed bits.
      if (field_bit) begin
         case (state)
            ARB: begin
               cnt_d = cnt + 7'd1;
               if (cnt < 7'(ID_LEN)) begin
                  id_d = {id[ID_LEN-2:0], bit_in};
               end else begin
                  rtr_d   = bit_in;
                  cnt_d   = '0;
                  state_d = CTRL;
               end
            end
            CTRL: begin
               cnt_d = cnt + 7'd1;
               case (cnt)
                  7'd0: begin
                     // Extended-format frames are not supported.
                     if (bit_in) begin
                        form_err_d  = 1'b1;
                        sample_en_d = 1'b0;
                        state_d     = WAIT_IDLE;
                     end
                  end
                  7'd1: ;
                  default: begin
                     dlc_n = {dlc[DLC_LEN-2:0], bit_in};
                     dlc_d = dlc_n;
                     if (cnt == 7'(DLC_LEN + 1)) begin
                        dlc_cap = (dlc_n > 4'd8) ? 4'd8 : dlc_n;
                        len_d   = rtr ? 7'd0 : {dlc_cap, 3'b000};
                        cnt_d   = '0;
                        state_d = (rtr || (dlc_n == 4'd0)) ? CRC : DATA;
                     end
                  end
               endcase
            end
            DATA: begin
               data_d[~cnt[5:0]] = bit_in;
               cnt_d = cnt + 7'd1;
               if (cnt == len - 7'd1) begin
                  cnt_d   = '0;
                  state_d = CRC;
               end
            end
            CRC: begin
               crc_rx_d = {crc_rx[CRC_LEN-2:0], bit_in};
               cnt_d    = cnt + 7'd1;
               if (cnt == 7'(CRC_LEN - 1)) begin
                  cnt_d   = '0;
                  state_d = CRC_DEL;
               end
            end
            default: ;
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= WAIT_IDLE;
         idle_cnt    <= '0;
         cnt         <= '0;
         len         <= '0;
         run_val     <= 1'b0;
         run_cnt     <= '0;
         id          <= '0;
         rtr         <= 1'b0;
         dlc         <= '0;
         data        <= '0;
         crc_rx      <= '0;
         sample_en   <= 1'b0;
         frame_valid <= 1'b0;
         stuff_err   <= 1'b0;
         form_err    <= 1'b0;
         busy        <= 1'b0;
`ifdef CAN_RX_CRC_CHECK_EN
         crc_err     <= 1'b0;
`endif
      end else begin
         state       <= state_d;
         idle_cnt    <= idle_cnt_d;
         cnt         <= cnt_d;
         len         <= len_d;
         run_val     <= run_val_d;
         run_cnt     <= run_cnt_d;
         id          <= id_d;
         rtr         <= rtr_d;
         dlc         <= dlc_d;
         data        <= data_d;
         crc_rx      <= crc_rx_d;
         sample_en   <= sample_en_d;
         frame_valid <= frame_valid_d;
         stuff_err   <= stuff_err_d;
         form_err    <= form_err_d;
         busy        <= busy_d;
`ifdef CAN_RX_CRC_CHECK_EN
         crc_err     <= crc_err_d;
`endif
      end
   end

endmodule

// File: tb/tb_can_rx_frame_ctrl.sv
// tb_can_rx_frame_ctrl: directed bench for can_rx_frame_ctrl.
// Frames are assembled bit by bit, stuffed, and fed through bit/bit_valid;
// decoded fields and result pulses are compared against hand-set values.
// With CAN_RX_CRC_CHECK_EN defined the crc_err port and a corrupted-CRC frame are added.
module tb_can_rx_frame_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx;
   logic        bit_in;
   logic        bit_valid;
   logic        sample_en;
   logic [10:0] id;
   logic        rtr;
   logic [3:0]  dlc;
   logic [63:0] data;
   logic [14:0] crc_rx;
   logic        frame_valid;
   logic        stuff_err;
   logic        form_err;
   logic        busy;
`ifdef CAN_RX_CRC_CHECK_EN
   logic        crc_err;
`endif

   int tests = 0;
   int fails = 0;
   int n_fv = 0, n_se = 0, n_fe = 0, n_ce = 0;
   int s_fv, s_se, s_fe, s_ce;
   logic post_fv, post_se, post_ser, post_fer, post_ce;
   logic fbits[$];
   logic sbits[$];
   logic [14:0] exp_crc;

   always #5 clk = ~clk;

   can_rx_frame_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx          (rx),
      .bit_in      (bit_in),
      .bit_valid   (bit_valid),
      .sample_en   (sample_en),
      .id          (id),
      .rtr         (rtr),
      .dlc         (dlc),
      .data        (data),
      .crc_rx      (crc_rx),
      .frame_valid (frame_valid),
      .stuff_err   (stuff_err),
      .form_err    (form_err),
      .busy        (busy)
`ifdef CAN_RX_CRC_CHECK_EN
      ,
      .crc_err     (crc_err)
`endif
   );

   // Pulse counters; a pulse wider than one clk counts more than once.
   always @(negedge clk) begin
      if (frame_valid) n_fv++;
      if (stuff_err)   n_se++;
      if (form_err)    n_fe++;
`ifdef CAN_RX_CRC_CHECK_EN
      if (crc_err)     n_ce++;
`endif
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [14:0] crc_model(input logic [14:0] c, input logic b);
      logic [15:0] t;
      t = {c, 1'b0};
      if (b ^ c[14]) t[14:0] = t[14:0] ^ 15'h4599;
      return t[14:0];
   endfunction

   // Build SOF..CRC (unstuffed into fbits, stuffed into sbits); crc_flip corrupts the sent CRC.
   task automatic build_frame(input logic [10:0] fid, input logic frtr, input logic fide,
                              input logic [3:0] fdlc, input logic [63:0] fdata,
                              input int ndata, input logic [14:0] crc_flip);
      logic [14:0] c;
      logic        rv;
      int          run;
      fbits.delete();
      sbits.delete();
      fbits.push_back(1'b0);
      for (int i = 10; i >= 0; i--) fbits.push_back(fid[i]);
      fbits.push_back(frtr);
      fbits.push_back(fide);
      fbits.push_back(1'b0);
      for (int i = 3; i >= 0; i--) fbits.push_back(fdlc[i]);
      for (int i = 0; i < ndata; i++) fbits.push_back(fdata[63-i]);
      c = '0;
      foreach (fbits[i]) c = crc_model(c, fbits[i]);
      exp_crc = c ^ crc_flip;
      for (int i = 14; i >= 0; i--) fbits.push_back(exp_crc[i]);
      run = 0;
      rv  = 1'b0;
      for (int i = 0; i < fbits.size(); i++) begin
         sbits.push_back(fbits[i]);
         if (run > 0 && fbits[i] == rv) run++;
         else begin rv = fbits[i]; run = 1; end
         if (run == 5 && i < fbits.size() - 1) begin
            sbits.push_back(~rv);
            rv  = ~rv;
            run = 1;
         end
      end
   endtask

   task automatic snap();
      s_fv = n_fv; s_se = n_se; s_fe = n_fe; s_ce = n_ce;
   endtask

   task automatic check_pulses(input string tag, input int fv, input int se, input int fe, input int ce);
      check(tag, {16'(n_fv - s_fv), 16'(n_se - s_se), 16'(n_fe - s_fe), 16'(n_ce - s_ce)},
                 {16'(fv), 16'(se), 16'(fe), 16'(ce)});
   endtask

   // One sampler strobe; post_* hold the outputs right after the strobe's edge.
   task automatic send_bit(input logic b);
      @(negedge clk);
      bit_valid = 1'b1;
      bit_in    = b;
      rx        = b;
      @(negedge clk);
      bit_valid = 1'b0;
      post_fv   = frame_valid;
      post_se   = sample_en;
      post_ser  = stuff_err;
      post_fer  = form_err;
`ifdef CAN_RX_CRC_CHECK_EN
      post_ce   = crc_err;
`else
      post_ce   = 1'b0;
`endif
      @(negedge clk);
   endtask

   task automatic send_stuffed(input int n);
      for (int i = 0; i < n; i++) send_bit(sbits[i]);
   endtask

   task automatic start_frame(input string tag);
      @(negedge clk);
      rx = 1'b0;
      @(negedge clk);
      check(tag, sample_en, 1);
   endtask

   // Recessive bus until busy drops; cycles counts negedges from the call.
   task automatic wait_idle(input string tag, output int cycles);
      rx     = 1'b1;
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (busy !== 1'b0 && cycles < 1500);
      check(tag, busy, 0);
   endtask

   initial begin
      int cyc;
      rst_n     = 1'b0;
      rx        = 1'b1;
      bit_in    = 1'b0;
      bit_valid = 1'b0;

      // Reset state.
      repeat (5) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_sample_en", sample_en, 0);
      check("rst_fields", {rtr, dlc, id, crc_rx}, 0);
      check("rst_data", data, 0);
      check("rst_pulses", {frame_valid, stuff_err, form_err}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("wait_idle_busy", busy, 1);
      wait_idle("idle_timeout0", cyc);
      check("idle_cycles", cyc, 1099);
      check("idle_outputs", {sample_en, rtr, dlc, id, crc_rx}, 0);

      // Standard frame id=0x123, dlc=1, data 0xA5.
      build_frame(11'h123, 1'b0, 1'b0, 4'd1, 64'hA500_0000_0000_0000, 8, 15'd0);
      snap();
      start_frame("f1_sof_en");
      send_stuffed(sbits.size());
      send_bit(1'b1);
      check("f1_valid", post_fv, 1);
      check("f1_se_drop", post_se, 0);
      check("f1_pulse_width", frame_valid, 0);
      check("f1_id", id, 11'h123);
      check("f1_rtr_dlc", {rtr, dlc}, {1'b0, 4'd1});
      check("f1_data", data, 64'hA500_0000_0000_0000);
      check("f1_crc", crc_rx, exp_crc);
      check_pulses("f1_pulses", 1, 0, 0, 0);
      wait_idle("idle_timeout1", cyc);

      // All-zero frame: stuff bits throughout id, ctrl and crc.
      build_frame(11'h000, 1'b0, 1'b0, 4'd0, 64'd0, 0, 15'd0);
      check("f2_stuffed_len", sbits.size(), 40);
      snap();
      start_frame("f2_sof_en");
      send_stuffed(sbits.size());
      send_bit(1'b1);
      check("f2_valid", post_fv, 1);
      check("f2_fields", {id, dlc, crc_rx}, 0);
      check_pulses("f2_pulses", 1, 0, 0, 0);
      wait_idle("idle_timeout2", cyc);

      // Sixth dominant bit in a row where a stuff bit belongs.
      snap();
      start_frame("f3_sof_en");
      for (int i = 0; i < 6; i++) send_bit(1'b0);
      check("f3_stuff_err", post_ser, 1);
      check("f3_se_drop", post_se, 0);
      check("f3_busy", busy, 1);
      send_bit(1'b0);
      check("f3_ignored", {post_ser, post_fer, post_fv}, 0);
      check_pulses("f3_pulses", 0, 1, 0, 0);
      wait_idle("idle_timeout3", cyc);

      // Dominant CRC delimiter.
      build_frame(11'h123, 1'b0, 1'b0, 4'd1, 64'hA500_0000_0000_0000, 8, 15'd0);
      snap();
      start_frame("f4_sof_en");
      send_stuffed(sbits.size());
      send_bit(1'b0);
      check("f4_form_err", {post_fer, post_fv, post_se}, 3'b100);
      check_pulses("f4_pulses", 0, 0, 1, 0);
      wait_idle("idle_timeout4", cyc);

      // IDE=1 aborts right after the IDE bit; partial id is kept.
      build_frame(11'h555, 1'b0, 1'b1, 4'd0, 64'd0, 0, 15'd0);
      snap();
      start_frame("f5_sof_en");
      send_stuffed(14);
      check("f5_form_err", {post_fer, post_se}, 2'b10);
      check("f5_id_kept", id, 11'h555);
      check_pulses("f5_pulses", 0, 0, 1, 0);
      wait_idle("idle_timeout5", cyc);

      // Recessive at the SOF sample point: glitch, silent return to WAIT_IDLE.
      snap();
      start_frame("f6_sof_en");
      send_bit(1'b1);
      check("f6_glitch", {post_se, post_fv, post_ser, post_fer, busy}, 5'b00001);
      check_pulses("f6_pulses", 0, 0, 0, 0);
      wait_idle("idle_timeout6", cyc);

      // Remote frame with dlc=4: no data bits.
      build_frame(11'h2A7, 1'b1, 1'b0, 4'd4, 64'd0, 0, 15'd0);
      snap();
      start_frame("f7_sof_en");
      send_stuffed(sbits.size());
      send_bit(1'b1);
      check("f7_valid", post_fv, 1);
      check("f7_fields", {id, rtr, dlc}, {11'h2A7, 1'b1, 4'd4});
      check("f7_data", data, 0);
      check("f7_crc", crc_rx, exp_crc);
      wait_idle("idle_timeout7", cyc);

      // dlc=15 is capped at 8 bytes.
      build_frame(11'h7F0, 1'b0, 1'b0, 4'd15, 64'h0123_4567_89AB_CDEF, 64, 15'd0);
      snap();
      start_frame("f8_sof_en");
      send_stuffed(sbits.size());
      send_bit(1'b1);
      check("f8_valid", post_fv, 1);
      check("f8_dlc", dlc, 15);
      check("f8_data", data, 64'h0123_4567_89AB_CDEF);
      check_pulses("f8_pulses", 1, 0, 0, 0);
      wait_idle("idle_timeout8", cyc);

      // Reset in the middle of DATA.
      build_frame(11'h0F0, 1'b0, 1'b0, 4'd8, 64'hDEAD_BEEF_0BAD_F00D, 64, 15'd0);
      snap();
      start_frame("f9_sof_en");
      send_stuffed(40);
      check("f9_mid_en", sample_en, 1);
      #2;
      rst_n = 1'b0;
      rx    = 1'b1;
      #1;
      check("f9_async_se", sample_en, 0);
      check("f9_async_state", {busy, id, data[63:56]}, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_idle("idle_timeout9", cyc);
      check("f9_idle_cycles", cyc, 1100);
      check_pulses("f9_pulses", 0, 0, 0, 0);

`ifdef CAN_RX_CRC_CHECK_EN
      // One CRC bit flipped.
      build_frame(11'h123, 1'b0, 1'b0, 4'd1, 64'hA500_0000_0000_0000, 8, 15'h0100);
      snap();
      start_frame("f10_sof_en");
      send_stuffed(sbits.size());
      send_bit(1'b1);
      check("f10_crc_err", {post_ce, post_fv, post_se}, 3'b100);
      check_pulses("f10_pulses", 0, 0, 0, 1);
      wait_idle("idle_timeout10", cyc);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
